// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-16 registered demultiplexer.
// Lane width, channel count and select width are fixed here for all users.
package demux_pkg;

  localparam int W  = 33;
  localparam int N  = 16;
  localparam int SW = 4;
  localparam int CW = 8;

  typedef logic [W-1:0]  lane_t;
  typedef logic [SW-1:0] sel_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot for a single output channel.
// A load always wins over a drain, so load+drain replaces the word with no bubble.
module demux_slot
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  lane_t load_data,
  output logic  valid,
  input  logic  ready,
  output lane_t data
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0] state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      // NOTE: the data register is reset as well, so no word from before a
      // reset can ever reappear on the output.
      data  <= '0;
    end else if (load) begin
      state <= FULL;
      data  <= load_data;
    end else if (ready && state == FULL) begin
      state <= EMPTY;
    end
  end

  assign valid = (state == FULL);

endmodule

// File: rtl/demux_1x16.sv
// Registered 1-to-16 demultiplexer: select decode, input-ready mux and a
// saturating counter of words dropped for disabled channels.
module demux_1x16
  import demux_pkg::*;
#(
  parameter int N_ACTIVE = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  lane_t          in_data,
  input  sel_t           in_sel,
  output logic [N-1:0]   out_valid,
  input  logic [N-1:0]   out_ready,
  output lane_t [N-1:0]  out_data,
  output cnt_t           drop_cnt
);

  logic sel_en;
  logic accept;

  assign sel_en = (int'(in_sel) < N_ACTIVE);

  // A disabled select is always accepted so upstream never stalls on it.
  assign in_ready = sel_en ? (!out_valid[in_sel] || out_ready[in_sel]) : 1'b1;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < N; k++) begin : g_slot
    logic load;
    assign load = accept && sel_en && (in_sel == sel_t'(k));

    demux_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (in_data),
      .valid     (out_valid[k]),
      .ready     (out_ready[k]),
      .data      (out_data[k])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (accept && !sel_en && drop_cnt != CNT_MAX) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_1x16.sv
// Bench for demux_1x16: two instances (all channels enabled, and 12 enabled)
// share stimulus and are compared each cycle against a behavioural model.
module tb_demux_1x16;
  import demux_pkg::*;

  localparam int NA [2] = '{16, 12};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  lane_t       in_data = '0;
  sel_t        in_sel = '0;
  logic [15:0] out_ready = '1;

  logic          in_ready16, in_ready12;
  logic [15:0]   out_valid16, out_valid12;
  lane_t [15:0]  out_data16, out_data12;
  cnt_t          drop16, drop12;

  int checks = 0;
  int failures = 0;

  // Model: per instance, per channel "slot holds a word" and the word held;
  // total drops counted without limit, saturated only when compared.
  bit    mv [2][16];
  lane_t md [2][16];
  int    drops [2];

  demux_1x16 #(.N_ACTIVE(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid16),
    .out_ready(out_ready), .out_data(out_data16), .drop_cnt(drop16)
  );

  demux_1x16 #(.N_ACTIVE(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid12),
    .out_ready(out_ready), .out_data(out_data12), .drop_cnt(drop12)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready(int m);
    int s;
    s = int'(in_sel);
    if (s >= NA[m]) return 1'b1;
    return !mv[m][s] || out_ready[s];
  endfunction

  function automatic int model_drop(int m);
    return (drops[m] > 255) ? 255 : drops[m];
  endfunction

  // Model update: drains first (they consume the old word), then the load.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        bit rdy;
        rdy = model_ready(m);
        for (int k = 0; k < 16; k++)
          if (mv[m][k] && out_ready[k]) mv[m][k] = 1'b0;
        if (in_valid && rdy) begin
          if (int'(in_sel) < NA[m]) begin
            mv[m][int'(in_sel)] = 1'b1;
            md[m][int'(in_sel)] = in_data;
          end else begin
            drops[m]++;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge rst);
    for (int m = 0; m < 2; m++) begin
      drops[m] = 0;
      for (int k = 0; k < 16; k++) mv[m][k] = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        logic [15:0] ov;
        logic        ir;
        logic [7:0]  dc;
        ov = (m == 0) ? out_valid16 : out_valid12;
        ir = (m == 0) ? in_ready16 : in_ready12;
        dc = (m == 0) ? drop16 : drop12;
        check($sformatf("model_in_ready[%0d]", m), 64'(ir), 64'(model_ready(m)));
        check($sformatf("model_drop_cnt[%0d]", m), 64'(dc), 64'(model_drop(m)));
        for (int k = 0; k < 16; k++) begin
          check($sformatf("model_out_valid[%0d][%0d]", m, k), 64'(ov[k]), 64'(mv[m][k]));
          if (mv[m][k])
            check($sformatf("model_out_data[%0d][%0d]", m, k),
                  64'((m == 0) ? out_data16[k] : out_data12[k]), 64'(md[m][k]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    lane_t a, b, c, d, e;
    a = 33'h0_AAAA_0001; b = 33'h1_BBBB_0002; c = 33'h0_CCCC_0003;
    d = 33'h1_DDDD_0004; e = 33'h0_EEEE_0005;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid16), 64'h0);
    check("reset_drop_cnt", 64'(drop16), 64'h0);
    check("reset_in_ready", 64'(in_ready16), 64'h1);
    @(negedge clk);
    rst = 1'b1;

    // Single word to channel 3, one-cycle latency
    in_valid = 1'b1; in_sel = 4'd3; in_data = 33'h1_2345_6789;
    step();
    check("t1_out_valid", 64'(out_valid16), 64'h0008);
    check("t1_out_data3", 64'(out_data16[3]), 64'h1_2345_6789);
    check("t1_drop_cnt", 64'(drop16), 64'h0);
    in_valid = 1'b0;
    step();
    check("t1_drained", 64'(out_valid16), 64'h0);

    // Back-pressure on channel 5
    out_ready = 16'hFFDF;
    in_valid = 1'b1; in_sel = 4'd5; in_data = a;
    step();
    check("t2_first_held", 64'(out_data16[5]), 64'(a));
    in_data = b;
    #1;
    check("t2_in_ready_stalled", 64'(in_ready16), 64'h0);
    step();
    check("t2_no_overwrite", 64'(out_data16[5]), 64'(a));
    check("t2_still_valid", 64'(out_valid16[5]), 64'h1);
    out_ready[5] = 1'b1;
    #1;
    check("t2_in_ready_released", 64'(in_ready16), 64'h1);
    step();
    check("t2_second_valid", 64'(out_valid16[5]), 64'h1);
    check("t2_second_data", 64'(out_data16[5]), 64'(b));

    // Channel 5 stalled, channel 6 flows
    out_ready[5] = 1'b0;
    in_sel = 4'd6; in_data = e;
    #1;
    check("t3_in_ready_ch6", 64'(in_ready16), 64'h1);
    step();
    check("t3_ch6_valid", 64'(out_valid16[6]), 64'h1);
    check("t3_ch6_data", 64'(out_data16[6]), 64'(e));
    check("t3_ch5_kept", 64'(out_data16[5]), 64'(b));
    in_valid = 1'b0;
    out_ready = '1;
    step();
    check("t3_all_drained", 64'(out_valid16), 64'h0);

    // Load and drain of channel 2 in the same cycle
    out_ready[2] = 1'b0;
    in_valid = 1'b1; in_sel = 4'd2; in_data = c;
    step();
    check("t4_loaded", 64'(out_data16[2]), 64'(c));
    out_ready[2] = 1'b1; in_data = d;
    step();
    check("t4_no_bubble", 64'(out_valid16[2]), 64'h1);
    check("t4_replaced", 64'(out_data16[2]), 64'(d));
    in_valid = 1'b0;
    step();
    check("t4_drained", 64'(out_valid16), 64'h0);

    // Drops on the 12-channel instance, through saturation
    for (int i = 0; i < 260; i++) begin
      in_valid = 1'b1;
      in_sel   = sel_t'(12 + (i % 4));
      in_data  = lane_t'({$urandom, $urandom});
      #1;
      check("t5_drop_in_ready", 64'(in_ready12), 64'h1);
      check("t5_no_out_valid", 64'(out_valid12), 64'h0);
      step();
    end
    in_valid = 1'b0;
    check("t5_drop_saturated", 64'(drop12), 64'd255);
    check("t5_drop16_zero", 64'(drop16), 64'h0);

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sel    = sel_t'($urandom_range(0, 15));
      in_data   = lane_t'({$urandom, $urandom});
      out_ready = 16'($urandom) | 16'($urandom);
      step();
    end

    // Fill every channel, then assert reset between clock edges
    in_valid = 1'b0; out_ready = '1;
    step(); step();
    out_ready = '0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_sel = sel_t'(k); in_data = lane_t'(k * 7 + 1);
      step();
    end
    in_valid = 1'b0;
    check("t6_all_full", 64'(out_valid16), 64'hFFFF);
    check("t6_full_data15", 64'(out_data16[15]), 64'd106);
    #1;
    rst = 1'b0;
    #1;
    check("t6_async_valid16", 64'(out_valid16), 64'h0);
    check("t6_async_valid12", 64'(out_valid12), 64'h0);
    check("t6_async_drop12", 64'(drop12), 64'h0);
    check("t6_async_in_ready", 64'(in_ready16), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = '1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1x16.md
# demux_1x16

Registered 1-to-16 demultiplexer that steers a single 33-bit input stream to one of 16 output channels using a 4-bit select. It is the distribution end of the datapath fed by the 16:1 lane multiplexer. Each output channel has a one-entry holding slot with its own valid/ready handshake, so a stalled channel blocks only traffic addressed to it. Traffic addressed to a disabled channel is dropped and counted.

## Interface
- W, 33, data lane width
- N, 16, number of output channels
- SW, 4, select width (2^SW >= N)
- N_ACTIVE, 16, enabled channels 0..N_ACTIVE-1; range 1..N
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- in_valid  in  1  input word present
- in_ready  out  1  input word accepted this cycle when in_valid=1
- in_data  in  W  input word
- in_sel  in  SW  destination channel, qualified by in_valid
- out_valid  out  N  per-channel slot holds a word
- out_ready  in  N  per-channel consumer accepts
- out_data  out  N x W  per-channel slot contents
- drop_cnt  out  8  count of words dropped for disabled select

## Operation
- Input transfer: in_valid && in_ready at posedge.
- Output transfer on channel k: out_valid[k] && out_ready[k] at posedge.
- Enabled select (in_sel < N_ACTIVE): in_ready = !out_valid[in_sel] || out_ready[in_sel]; purely combinational from in_sel, out_valid and out_ready; independent of in_valid.
- Disabled select (in_sel >= N_ACTIVE): in_ready = 1. Word is discarded. drop_cnt increments by 1 per transfer and saturates at 255.
- On input transfer to channel k: out_data[k] <= in_data and out_valid[k] <= 1.
- Channel k output transfer with no load: out_valid[k] <= 0. out_data[k] keeps its value.
- Load and drain of channel k in the same cycle: new word replaces old; out_valid[k] stays 1; no bubble.
- Channels drain independently; any subset of out_ready may be high concurrently.
- Data is never duplicated, reordered within a channel, or overwritten while out_valid=1 and out_ready=0.
- out_data[k] is don't-care when out_valid[k]=0. The bench must not check it.

## Timing
- Latency: word accepted at edge t appears on out_data[k] with out_valid[k]=1 after edge t, i.e. one cycle.
- Throughput: one word per cycle when the target channel is empty or draining.
- Reset (rst=0, any time, asynchronous): out_valid=0, out_data=0, drop_cnt=0.
  - Words held in slots are lost. No partial state survives.
  - in_ready is combinational and is 1 during reset when in_sel addresses an empty slot. Upstream must not count transfers during reset.
- First transfer after release: rst=1 sampled at a posedge. Release is synchronized by the system.
- Per-channel slot state machine, 2 states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load+drain, or on neither.
- in_sel == N_ACTIVE-1 is enabled. in_sel == N_ACTIVE is disabled.
- drop_cnt at 255 plus another drop: stays 255.

## Structure
- Package demux_pkg: W, N, SW constants; typedef lane_t (logic [W-1:0]); typedef sel_t (logic [SW-1:0]).
- Sub-module demux_slot: one-entry holding register with load/valid/ready. Instantiated N times via generate.
- Top level contains only the select decode, in_ready mux and drop counter.

## Test plan
- Reset then in_sel=3, in_data=0x1_2345_6789, out_ready=all 1 -> out_valid[3]=1 one cycle later with that data; other out_valid stay 0; drop_cnt=0.
- out_ready[5]=0, two words to channel 5 on consecutive cycles -> first held, in_ready=0 on second until out_ready[5]=1; then second delivered in order.
- Channel 5 stalled; word to channel 6 -> in_ready=1, channel 6 delivers; channel 5 still holds its word.
- Channel 2 full, out_ready[2]=1 with a new word to channel 2 in the same cycle -> out_valid[2] stays 1, data replaced, no bubble.
- N_ACTIVE=12: 260 words with in_sel=12..15 -> all accepted, no out_valid asserted, drop_cnt=255.
- Channels 0..15 loaded, rst=0 mid-cycle -> out_valid=0 and drop_cnt=0 immediately, without waiting for a clk edge.
